// File: rtl/seq_stepper_pkg.sv
// seq_stepper_pkg
// Shared types and helpers for the one-hot step sequencer.
//   mode_e    : auto-advance behaviour (rotate or ping-pong)
//   dir_e     : ping-pong travel direction
//   clamp_len : forces a requested loop length into 1..width
package seq_stepper_pkg;

    typedef enum logic {
        MODE_ROTATE   = 1'b0,
        MODE_PINGPONG = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_e;

    // A zero length would leave no legal position, so it collapses to one step.
    function automatic int clamp_len(input int len, input int width);
        if (len <= 0) begin
            return 1;
        end else if (len > width) begin
            return width;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_prescaler.sv
// seq_prescaler
// Tempo prescaler: counts clk cycles and emits a one-cycle tick every
// i_period+1 cycles while enabled.
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   i_clear  : restart the count from zero (suppresses a tick this cycle)
//   i_en     : count enable; when low the count is held at zero
//   i_period : tick interval minus one
//   o_tick   : combinational tick, valid for the current cycle's edge
module seq_prescaler #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [PER_W-1:0] i_period,
    output logic             o_tick
);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] w_cnt_next;

    always_comb begin
        o_tick     = 1'b0;
        w_cnt_next = r_cnt + PER_W'(1);
        if (i_clear || !i_en) begin
            w_cnt_next = '0;
        end else if (r_cnt == i_period) begin
            o_tick     = 1'b1;
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/seq_stepper.sv
// seq_stepper
// Parametrised one-hot step sequencer with manual stepping, programmable
// loop length and tempo-driven auto-advance (rotate or ping-pong).
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   srst      : synchronous return-to-home, active-high
//   go_left   : manual step toward MSB (index decrement)
//   go_right  : manual step toward LSB (index increment)
//   auto_en   : enable tempo-driven auto-advance
//   mode      : 0 = rotate, 1 = ping-pong (auto-advance only)
//   period    : auto tick interval minus one, in clk cycles
//   len       : active loop length (clamped to 1..WIDTH)
//   seq_out   : one-hot step, bit WIDTH-1-step_idx set
//   step_idx  : current step index, 0 = home
//   step_tick : one-cycle pulse after each auto-advance
//   wrap      : one-cycle pulse on loop wrap or ping-pong bounce
module seq_stepper
    import seq_stepper_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PER_W = 16,
    parameter int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             go_left,
    input  logic             go_right,
    input  logic             auto_en,
    input  logic             mode,
    input  logic [PER_W-1:0] period,
    input  logic [IDX_W-1:0] len,
    output logic [WIDTH-1:0] seq_out,
    output logic [IDX_W-1:0] step_idx,
    output logic             step_tick,
    output logic             wrap
);

    logic [IDX_W-1:0] r_pos;
    dir_e             r_dir;
    logic             r_step_tick;
    logic             r_wrap;

    logic [IDX_W-1:0] w_pos_next;
    dir_e             w_dir_next;
    logic             w_step_tick_next;
    logic             w_wrap_next;

    logic [IDX_W-1:0] w_len_l;
    logic [IDX_W-1:0] w_last;
    logic             w_fix;
    logic             w_clear;
    logic             w_tick;
    mode_e            w_mode;

    assign w_len_l = IDX_W'(clamp_len(int'(len), WIDTH));
    assign w_last  = w_len_l - IDX_W'(1);
    assign w_fix   = (r_pos >= w_len_l);
    assign w_mode  = mode_e'(mode);

    // Any event that outranks the auto tick restarts the tempo count.
    assign w_clear = srst | w_fix | go_left | go_right;

    seq_prescaler #(
        .PER_W (PER_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_en     (auto_en),
        .i_period (period),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_pos_next       = r_pos;
        w_dir_next       = r_dir;
        w_step_tick_next = 1'b0;
        w_wrap_next      = 1'b0;
        if (srst) begin
            w_pos_next = '0;
            w_dir_next = DIR_FWD;
        end else if (w_fix) begin
            // Length shrank under the current position: go home silently.
            w_pos_next = '0;
        end else if (go_left) begin
            w_wrap_next = (r_pos == '0);
            w_pos_next  = (r_pos == '0) ? w_last : r_pos - IDX_W'(1);
        end else if (go_right) begin
            w_wrap_next = (r_pos == w_last);
            w_pos_next  = (r_pos == w_last) ? '0 : r_pos + IDX_W'(1);
        end else if (w_tick) begin
            w_step_tick_next = 1'b1;
            if (w_mode == MODE_ROTATE) begin
                w_wrap_next = (r_pos == w_last);
                w_pos_next  = (r_pos == w_last) ? '0 : r_pos + IDX_W'(1);
            end else if (r_dir == DIR_FWD && r_pos == w_last) begin
                // Bounce off the far end; a one-step loop stays at 0.
                w_dir_next  = DIR_BWD;
                w_wrap_next = 1'b1;
                w_pos_next  = (w_len_l >= IDX_W'(2)) ? w_len_l - IDX_W'(2) : '0;
            end else if (r_dir == DIR_BWD && r_pos == '0) begin
                w_dir_next  = DIR_FWD;
                w_wrap_next = 1'b1;
                w_pos_next  = (w_len_l >= IDX_W'(2)) ? IDX_W'(1) : '0;
            end else if (r_dir == DIR_FWD) begin
                w_pos_next = r_pos + IDX_W'(1);
            end else begin
                w_pos_next = r_pos - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos       <= '0;
            r_dir       <= DIR_FWD;
            r_step_tick <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_pos       <= w_pos_next;
            r_dir       <= w_dir_next;
            r_step_tick <= w_step_tick_next;
            r_wrap      <= w_wrap_next;
        end
    end

    // Index 0 maps to the MSB.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
        assign seq_out[gi] = (r_pos == IDX_W'(WIDTH - 1 - gi));
    end

    assign step_idx  = r_pos;
    assign step_tick = r_step_tick;
    assign wrap      = r_wrap;

endmodule

// File: doc/seq_stepper.md
Name: seq_stepper

Overview:
- Parametrised one-hot step sequencer for the audio mixer. Successor to the fixed 8-bit rotate sequencer.
- Adds configurable width, programmable loop length, tempo-driven auto-advance, rotate/ping-pong modes, step index output and wrap indication.
- Sits between the control/UI logic (manual step pulses, tempo settings) and the channel-select / pattern logic that consumes the one-hot step.

Parameters:
- WIDTH, 8, number of steps; one-hot output width (>=2).
- PER_W, 16, width of the tempo period register.
- IDX_W, $clog2(WIDTH)+1, width of the len input and step_idx output (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- srst  in  1  synchronous return-to-home, active-high.
- go_left  in  1  manual step pulse toward MSB (index decrement).
- go_right  in  1  manual step pulse toward LSB (index increment).
- auto_en  in  1  enables tempo-driven auto-advance.
- mode  in  1  0 = ROTATE, 1 = PINGPONG (auto-advance only).
- period  in  PER_W  auto tick interval minus one, in clk cycles.
- len  in  IDX_W  active loop length in steps.
- seq_out  out  WIDTH  one-hot step; bit (WIDTH-1-step_idx) set.
- step_idx  out  IDX_W  current step index, 0 = home.
- step_tick  out  1  one-cycle pulse on each auto-advance.
- wrap  out  1  one-cycle pulse on loop wrap or ping-pong end bounce.

Behaviour:
- State: pos (index), dir (0 = fwd/increment), cnt (PER_W prescaler). All registered. seq_out is decoded from pos.
- Reset (rst_n = 0 at a clk edge): pos = 0, dir = 0, cnt = 0, step_tick = 0, wrap = 0. Hence seq_out = MSB only (8'h80 for WIDTH = 8) and step_idx = 0.
- Effective length L: len clamped to 1..WIDTH. len = 0 gives 1; len > WIDTH gives WIDTH.
- Priority per cycle:
  1. rst_n low.
  2. srst: same values as reset.
  3. Out-of-range fix.
  4. go_left.
  5. go_right.
  6. Auto tick.
- Out-of-range fix: if pos >= L (len reduced), pos <= 0 and cnt <= 0. No wrap, no step_tick.
- go_left: pos <= (pos == 0) ? L-1 : pos-1. Sets wrap if pos was 0. cnt <= 0.
- go_right: pos <= (pos == L-1) ? 0 : pos+1. Sets wrap if pos was L-1. cnt <= 0.
- go_left and go_right in the same cycle: go_left wins.
- Manual steps always use rotate semantics and never change dir.
- Prescaler, when auto_en = 1 and no higher-priority event:
  - If cnt == period: tick; cnt <= 0.
  - Else cnt <= cnt + 1.
  - Tick interval is period+1 cycles; period = 0 ticks every cycle.
  - auto_en = 0 holds cnt at 0.
- Auto tick, ROTATE: same as go_right.
- Auto tick, PINGPONG:
  - dir = 0 and pos == L-1: dir <= 1, pos <= max(L-2, 0), wrap.
  - dir = 1 and pos == 0: dir <= 0, pos <= min(1, L-1), wrap.
  - Otherwise step pos in direction dir.
  - L == 1: pos stays 0 and wrap still pulses.
- step_tick pulses for one cycle after any auto tick edge.
- Latency: an event sampled at edge k is visible on seq_out, step_idx and the pulses after edge k (one cycle). Pulses deassert the next cycle unless a new event occurs.
- Mode switch mid-run takes effect at the next tick; pos is preserved and dir is preserved. Entering ROTATE ignores dir.
- Invariant: seq_out is always exactly one-hot, with a set bit within the top L positions.

Decomposition:
- Package seq_stepper_pkg holds:
  - mode_e enum {MODE_ROTATE, MODE_PINGPONG}.
  - dir_e enum {DIR_FWD, DIR_BWD}.
  - Function clamp_len(len, WIDTH).
- One sub-module, seq_prescaler (cnt, period compare, clear, enable -> tick). The rest is a single next-state block.

Test Plan:
- Reset/home: rst_n = 0 then 1, WIDTH = 8 -> seq_out = 8'h80, step_idx = 0, pulses 0. srst mid-run at pos 5 -> 8'h80 next cycle.
- Manual rotate: L = 8, three go_left pulses from home -> 8'h01, 8'h02, 8'h04; wrap on the first only. go_left and go_right together -> go_left result.
- Auto ROTATE: period = 3, L = 4, auto_en = 1 -> step every 4 cycles: 8'h80, 8'h40, 8'h20, 8'h10, 8'h80. wrap with the return to 8'h80. step_tick on every step.
- Auto PINGPONG: period = 0, L = 3 -> idx 0,1,2,1,0,1. wrap on reaching idx 2->1 and 0->1 bounces. L = 1 -> idx stays 0 and wrap pulses every cycle.
- Length shrink: pos = 6, len changed to 4 -> pos = 0 next cycle, no wrap. len = 0 behaves as L = 1. len = 15 behaves as L = 8.
- Manual overrides auto: period = 9, go_right at cnt = 7 -> immediate step, cnt cleared, next auto step 10 cycles later.
